// File: rtl/sfp_seq_ctrl_if.sv
// Control bundle between one sfp_seq_ctrl and its sfp_row / pmem / peer core.
// The master side is the sequencer; the slave side is whatever it drives.
interface sfp_seq_ctrl_if #(
  parameter int addr_w = 5
);
  logic              start;
  logic              peer_ready;
  logic              local_ready;
  logic              pmem_rd;
  logic [addr_w-1:0] pmem_rd_addr;
  logic              pmem_wr;
  logic [addr_w-1:0] pmem_wr_addr;
  logic              acc;
  logic              div;
  logic              fifo_ext_rd;
  logic              busy;
  logic              done;

  modport master (
    input  start, peer_ready,
    output local_ready, pmem_rd, pmem_rd_addr, pmem_wr, pmem_wr_addr,
           acc, div, fifo_ext_rd, busy, done
  );

  modport slave (
    output start, peer_ready,
    input  local_ready, pmem_rd, pmem_rd_addr, pmem_wr, pmem_wr_addr,
           acc, div, fifo_ext_rd, busy, done
  );
endinterface

// File: rtl/sfp_seq_ctrl.sv
// Two-phase sequencer for one core's sfp_row softmax pass: accumulate row sums,
// rendezvous with the peer core, then divide and write normalized rows back.
module sfp_seq_ctrl #(
  parameter int num_rows = 8,
  parameter int addr_w   = 5,
  parameter int in_base  = 0,
  parameter int out_base = 16
) (
  input  logic          clk,
  input  logic          reset,
  sfp_seq_ctrl_if.master bus
);

  localparam int               row_w    = 5;
  localparam logic [row_w-1:0] last_row = row_w'(num_rows - 1);

  typedef enum logic [2:0] {
    IDLE, ACC, ACC_DRAIN, SYNC, DIV, DIV_DRAIN1, DIV_DRAIN2, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [row_w-1:0] row_q, row_d;
  logic [row_w-1:0] wr_row_q, wr_row_d;
  logic             acc_q, acc_d;
  logic             div_q, div_d;
  logic             wr_q, wr_d;
  logic             rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      wr_row_q <= '0;
      acc_q    <= 1'b0;
      div_q    <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      wr_row_q <= wr_row_d;
      acc_q    <= acc_d;
      div_q    <= div_d;
      wr_q     <= wr_d;
    end
  end

  // row stays zero outside ACC/DIV, so every state entry sees a cleared counter
  always_comb begin
    state_d = state_q;
    row_d   = '0;
    case (state_q)
      IDLE:       if (bus.start) state_d = ACC;
      ACC: begin
        if (row_q == last_row) state_d = ACC_DRAIN;
        else                   row_d   = row_q + row_w'(1);
      end
      ACC_DRAIN:  state_d = SYNC;
      SYNC:       if (bus.peer_ready) state_d = DIV;
      DIV: begin
        if (row_q == last_row) state_d = DIV_DRAIN1;
        else                   row_d   = row_q + row_w'(1);
      end
      DIV_DRAIN1: state_d = DIV_DRAIN2;
      DIV_DRAIN2: state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // acc/div trail the read by one cycle; the write trails div to match sfp_out
  always_comb begin
    acc_d    = (state_q == ACC);
    div_d    = (state_q == DIV);
    wr_d     = div_q;
    wr_row_d = wr_row_q;
    if (state_q == SYNC) wr_row_d = '0;
    else if (wr_q)       wr_row_d = wr_row_q + row_w'(1);
  end

  assign rd_en            = (state_q == ACC) || (state_q == DIV);
  assign bus.pmem_rd      = rd_en;
  assign bus.pmem_rd_addr = rd_en ? addr_w'(in_base) + addr_w'(row_q) : '0;
  assign bus.pmem_wr      = wr_q;
  assign bus.pmem_wr_addr = wr_q ? addr_w'(out_base) + addr_w'(wr_row_q) : '0;
  assign bus.acc          = acc_q;
  assign bus.div          = div_q;
  assign bus.fifo_ext_rd  = div_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  // held through DONE so a late peer can never miss the rendezvous
  assign bus.local_ready  = (state_q == SYNC) || (state_q == DIV) ||
                            (state_q == DIV_DRAIN1) || (state_q == DIV_DRAIN2) ||
                            (state_q == DONE);

endmodule

// File: tb/tb_sfp_seq_ctrl.sv
// Self-checking bench for sfp_seq_ctrl: event timing predicted from start and
// rendezvous cycles, compared every cycle against three DUT instances.
module tb_sfp_seq_ctrl;

  localparam int IN_BASE  = 0;
  localparam int OUT_BASE = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, start_b, start_c;
  logic peer_a, peer_c;
  logic cross_mode;

  int tests_run    = 0;
  int tests_failed = 0;

  sfp_seq_ctrl_if #(.addr_w(5)) bus_a ();
  sfp_seq_ctrl_if #(.addr_w(5)) bus_b ();
  sfp_seq_ctrl_if #(.addr_w(5)) bus_c ();

  assign bus_a.start      = start_a;
  assign bus_b.start      = start_b;
  assign bus_c.start      = start_c;
  assign bus_a.peer_ready = cross_mode ? bus_b.local_ready : peer_a;
  assign bus_b.peer_ready = cross_mode & bus_a.local_ready;
  assign bus_c.peer_ready = peer_c;

  sfp_seq_ctrl #(.num_rows(8), .addr_w(5), .in_base(IN_BASE), .out_base(OUT_BASE))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  sfp_seq_ctrl #(.num_rows(8), .addr_w(5), .in_base(IN_BASE), .out_base(OUT_BASE))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  sfp_seq_ctrl #(.num_rows(1), .addr_w(5), .in_base(IN_BASE), .out_base(OUT_BASE))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  // {busy, done, local_ready, pmem_rd, rd_addr, pmem_wr, wr_addr, acc, div, fifo_ext_rd}
  logic [17:0] obs_a, obs_b, obs_c;
  assign obs_a = {bus_a.busy, bus_a.done, bus_a.local_ready, bus_a.pmem_rd, bus_a.pmem_rd_addr,
                  bus_a.pmem_wr, bus_a.pmem_wr_addr, bus_a.acc, bus_a.div, bus_a.fifo_ext_rd};
  assign obs_b = {bus_b.busy, bus_b.done, bus_b.local_ready, bus_b.pmem_rd, bus_b.pmem_rd_addr,
                  bus_b.pmem_wr, bus_b.pmem_wr_addr, bus_b.acc, bus_b.div, bus_b.fifo_ext_rd};
  assign obs_c = {bus_c.busy, bus_c.done, bus_c.local_ready, bus_c.pmem_rd, bus_c.pmem_rd_addr,
                  bus_c.pmem_wr, bus_c.pmem_wr_addr, bus_c.acc, bus_c.div, bus_c.fifo_ext_rd};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: n rows, start pulse at cycle s, divide phase beginning at cycle ds.
  function automatic logic [17:0] modelVec(input int n, input int s, input int ds, input int t);
    int         done_c;
    logic       busy, dn, lr, rd, wr, acc, dv;
    logic [4:0] ra, wa;
    done_c = ds + n + 2;
    busy = (t > s) && (t <= done_c);
    dn   = (t == done_c);
    lr   = (t >= s + n + 2) && (t <= done_c);
    acc  = (t >= s + 2) && (t <= s + n + 1);
    dv   = (t >= ds + 1) && (t <= ds + n);
    rd   = 1'b0;
    ra   = '0;
    wr   = 1'b0;
    wa   = '0;
    if (t >= s + 1 && t <= s + n) begin
      rd = 1'b1;
      ra = 5'(IN_BASE + (t - s - 1));
    end else if (t >= ds && t < ds + n) begin
      rd = 1'b1;
      ra = 5'(IN_BASE + (t - ds));
    end
    if (t >= ds + 2 && t <= ds + n + 1) begin
      wr = 1'b1;
      wa = 5'(OUT_BASE + (t - ds - 2));
    end
    return {busy, dn, lr, rd, ra, wr, wa, acc, dv, dv};
  endfunction

  // mode 0: dut_a alone, mode 1: dut_c (num_rows=1), mode 2: dut_a/dut_b cross-wired
  task automatic applyStimulus(input string tag, input int mode, input int peer_rise,
                               input int peer_drop, input int restart_at, input int reset_at);
    int          n, ds, horizon, fifo_a, fifo_b, misalign;
    logic [17:0] exp_v;
    n = (mode == 1) ? 1 : 8;
    if (mode == 2) ds = n + 6;
    else           ds = ((peer_rise > n + 2) ? peer_rise : n + 2) + 1;
    horizon    = ds + n + 6;
    cross_mode = (mode == 2);
    fifo_a     = 0;
    fifo_b     = 0;
    misalign   = 0;
    for (int t = 0; t < horizon; t++) begin
      start_a = (mode == 0) ? (t == 0 || t == restart_at) : (mode == 2 && t == 0);
      start_b = (mode == 2 && t == 3);
      start_c = (mode == 1 && (t == 0 || t == restart_at));
      peer_a  = (mode == 0 && t >= peer_rise && t < peer_drop);
      peer_c  = (mode == 1 && t >= peer_rise && t < peer_drop);
      reset   = (t == reset_at);
      @(negedge clk);
      exp_v = modelVec(n, 0, ds, t);
      if (reset_at >= 0 && t > reset_at) exp_v = '0;
      if (mode == 1) checkOutput($sformatf("%s c t=%0d", tag, t), 32'(obs_c), 32'(exp_v));
      else           checkOutput($sformatf("%s a t=%0d", tag, t), 32'(obs_a), 32'(exp_v));
      if (mode == 2) begin
        checkOutput($sformatf("%s b t=%0d", tag, t), 32'(obs_b), 32'(modelVec(n, 3, ds, t)));
        fifo_a   += int'(bus_a.fifo_ext_rd);
        fifo_b   += int'(bus_b.fifo_ext_rd);
        misalign += int'(bus_a.div != bus_b.div);
      end
      @(posedge clk);
      #1;
    end
    if (mode == 2) begin
      checkOutput({tag, " fifo_cnt_a"}, 32'(fifo_a), 32'(n));
      checkOutput({tag, " fifo_cnt_b"}, 32'(fifo_b), 32'(n));
      checkOutput({tag, " div_align"}, 32'(misalign), 32'd0);
    end
    start_a    = 1'b0;
    start_b    = 1'b0;
    start_c    = 1'b0;
    peer_a     = 1'b0;
    peer_c     = 1'b0;
    reset      = 1'b0;
    cross_mode = 1'b0;
  endtask

  initial begin
    int mode, n, pr, ds, drop, rs;
    reset      = 1'b1;
    start_a    = 1'b0;
    start_b    = 1'b0;
    start_c    = 1'b0;
    peer_a     = 1'b0;
    peer_c     = 1'b0;
    cross_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset a", 32'(obs_a), 32'd0);
    checkOutput("reset b", 32'(obs_b), 32'd0);
    checkOutput("reset c", 32'(obs_c), 32'd0);
    @(posedge clk);
    #1;

    applyStimulus("basic",     0, 0,  1000, -1, -1);
    applyStimulus("late_peer", 0, 25, 1000, -1, -1);
    applyStimulus("restart",   0, 0,  1000,  5, -1);
    applyStimulus("mid_reset", 0, 0,  1000, -1, 14);
    applyStimulus("post_rst",  0, 0,  1000, -1, -1);
    applyStimulus("one_row",   1, 0,  1000, -1, -1);
    applyStimulus("cross",     2, 0,  0,    -1, -1);

    for (int i = 0; i < 8; i++) begin
      mode = int'($urandom_range(0, 1));
      n    = (mode == 1) ? 1 : 8;
      pr   = int'($urandom_range(0, 30));
      ds   = ((pr > n + 2) ? pr : n + 2) + 1;
      drop = ds + int'($urandom_range(0, 12));
      rs   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, ds + n + 2)) : -1;
      applyStimulus($sformatf("rand%0d", i), mode, pr, drop, rs, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
